// File: rtl/pl_pkg.sv
`default_nettype none
// ============================================================================
// pl_pkg : shared defaults and operand-select encoding for the ID scoreboard
// Revision: 1.0
// ============================================================================
package pl_pkg;

  localparam int c_default_nreg   = 32;
  localparam int c_default_dw     = 32;
  localparam int c_default_maxlat = 8;

  typedef enum logic [1:0] {
    ZERO = 2'd0,
    RF   = 2'd1,
    FWD  = 2'd2
  } fwd_sel_t;

endpackage : pl_pkg
`default_nettype wire

// File: rtl/pl_sb_fwdmux.sv
`default_nettype none
// ============================================================================
// pl_sb_fwdmux : one source operand, chosen from zero / forward bus / regfile
// Revision: 1.0
// ============================================================================
module pl_sb_fwdmux
  import pl_pkg::*;
#(
  parameter int AW = 5,
  parameter int DW = 32
) (
  input  logic [AW-1:0] src,
  input  logic [DW-1:0] rf_q,
  input  logic          fwd_valid,
  input  logic [AW-1:0] fwd_rn,
  input  logic [DW-1:0] fwd_data,
  output logic [DW-1:0] dout
);

  fwd_sel_t sel;

  // r0 wins over the bus so a stray r0 tag can never leak data into a source
  always_comb begin
    if (src == '0) begin
      sel = ZERO;
    end else if (fwd_valid && (fwd_rn == src)) begin
      sel = FWD;
    end else begin
      sel = RF;
    end
  end

  always_comb begin
    case (sel)
      ZERO:    dout = '0;
      FWD:     dout = fwd_data;
      default: dout = rf_q;
    endcase
  end

endmodule : pl_sb_fwdmux
`default_nettype wire

// File: rtl/pl_id_scoreboard.sv
`default_nettype none
// ============================================================================
// pl_id_scoreboard : decode-stage countdown scoreboard, writeback-slot
//                    reservation and operand forwarding for variable latency
// Revision: 1.0
// ============================================================================
module pl_id_scoreboard
  import pl_pkg::*;
#(
  parameter int NREG   = c_default_nreg,
  parameter int AW     = $clog2(NREG),
  parameter int DW     = c_default_dw,
  parameter int MAXLAT = c_default_maxlat,
  parameter int CW     = $clog2(MAXLAT + 1)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            id_valid,
  input  logic [AW-1:0]   id_rs,
  input  logic [AW-1:0]   id_rt,
  input  logic            id_use_rs,
  input  logic            id_use_rt,
  input  logic            id_wreg,
  input  logic [AW-1:0]   id_rd,
  input  logic [CW-1:0]   id_lat,
  input  logic            flush,
  input  logic [DW-1:0]   rf_q1,
  input  logic [DW-1:0]   rf_q2,
  input  logic            fwd_valid,
  input  logic [AW-1:0]   fwd_rn,
  input  logic [DW-1:0]   fwd_data,
  output logic            stall,
  output logic            issue,
  output logic [DW-1:0]   da,
  output logic [DW-1:0]   db,
  output logic [NREG-1:0] pending
);

  logic [CW-1:0]     cnt_rd [NREG];
  logic [MAXLAT-1:0] slot_q;
  logic [MAXLAT-1:0] slot_d;
  logic              raw_rs;
  logic              raw_rt;
  logic              waw;
  logic              slot_conf;
  logic              wr_en;

  // cnt == 1 means the value is on the bus now and is picked up by the mux
  always_comb begin
    raw_rs    = id_use_rs && (id_rs != '0) && (cnt_rd[id_rs] > CW'(1));
    raw_rt    = id_use_rt && (id_rt != '0) && (cnt_rd[id_rt] > CW'(1));
    waw       = id_wreg && (id_rd != '0) && (cnt_rd[id_rd] > id_lat);
    slot_conf = 1'b0;
    for (int k = 0; k < MAXLAT; k++) begin
      if (slot_q[k] && (id_lat == CW'(k))) begin
        slot_conf = 1'b1;
      end
    end
    slot_conf = slot_conf && id_wreg;
    stall     = id_valid && (raw_rs || raw_rt || waw || slot_conf);
  end

  assign issue = id_valid && !stall && !flush;
  assign wr_en = issue && id_wreg && (id_rd != '0);

  always_comb begin
    slot_d = slot_q >> 1;
    if (wr_en) begin
      for (int k = 0; k < MAXLAT; k++) begin
        if (id_lat == CW'(k + 1)) begin
          slot_d[k] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      slot_q <= '0;
    end else begin
      slot_q <= slot_d;
    end
  end

  assign cnt_rd[0]  = '0;
  assign pending[0] = 1'b0;

  generate
    for (genvar r = 1; r < NREG; r++) begin : g_cnt
      logic [CW-1:0] cnt_q;
      logic [CW-1:0] cnt_d;

      // a fresh issue to this register overrides the running countdown
      always_comb begin
        cnt_d = cnt_q;
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end
        if (wr_en && (id_rd == AW'(r))) begin
          cnt_d = id_lat;
        end
      end

      always_ff @(posedge clock) begin
        if (reset) begin
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_d;
        end
      end

      assign cnt_rd[r]  = cnt_q;
      assign pending[r] = (cnt_q != '0);
    end
  endgenerate

  pl_sb_fwdmux #(
    .AW (AW),
    .DW (DW)
  ) u_fwdmux_a (
    .src       (id_rs),
    .rf_q      (rf_q1),
    .fwd_valid (fwd_valid),
    .fwd_rn    (fwd_rn),
    .fwd_data  (fwd_data),
    .dout      (da)
  );

  pl_sb_fwdmux #(
    .AW (AW),
    .DW (DW)
  ) u_fwdmux_b (
    .src       (id_rt),
    .rf_q      (rf_q2),
    .fwd_valid (fwd_valid),
    .fwd_rn    (fwd_rn),
    .fwd_data  (fwd_data),
    .dout      (db)
  );

endmodule : pl_id_scoreboard
`default_nettype wire

// File: tb/tb_pl_id_scoreboard.sv
`default_nettype none
// ============================================================================
// tb_pl_id_scoreboard : directed hazard / forwarding scenarios for the ID scoreboard
// Revision: 1.0
// ============================================================================
module tb_pl_id_scoreboard;

  logic        clock;
  logic        reset;
  logic        id_valid;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic        id_use_rs;
  logic        id_use_rt;
  logic        id_wreg;
  logic [4:0]  id_rd;
  logic [3:0]  id_lat;
  logic        flush;
  logic [31:0] rf_q1;
  logic [31:0] rf_q2;
  logic        fwd_valid;
  logic [4:0]  fwd_rn;
  logic [31:0] fwd_data;
  logic        stall;
  logic        issue;
  logic [31:0] da;
  logic [31:0] db;
  logic [31:0] pending;

  int n_tests = 0;
  int n_fail  = 0;

  pl_id_scoreboard dut (
    .clock     (clock),
    .reset     (reset),
    .id_valid  (id_valid),
    .id_rs     (id_rs),
    .id_rt     (id_rt),
    .id_use_rs (id_use_rs),
    .id_use_rt (id_use_rt),
    .id_wreg   (id_wreg),
    .id_rd     (id_rd),
    .id_lat    (id_lat),
    .flush     (flush),
    .rf_q1     (rf_q1),
    .rf_q2     (rf_q2),
    .fwd_valid (fwd_valid),
    .fwd_rn    (fwd_rn),
    .fwd_data  (fwd_data),
    .stall     (stall),
    .issue     (issue),
    .da        (da),
    .db        (db),
    .pending   (pending)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    id_valid  = 1'b0;
    id_rs     = '0;
    id_rt     = '0;
    id_use_rs = 1'b0;
    id_use_rt = 1'b0;
    id_wreg   = 1'b0;
    id_rd     = '0;
    id_lat    = 4'd1;
    flush     = 1'b0;
    rf_q1     = '0;
    rf_q2     = '0;
    fwd_valid = 1'b0;
    fwd_rn    = '0;
    fwd_data  = '0;
  endtask

  task automatic wr(input logic [4:0] rd, input logic [3:0] lat);
    id_valid = 1'b1;
    id_wreg  = 1'b1;
    id_rd    = rd;
    id_lat   = lat;
  endtask

  task automatic fwd(input logic [4:0] rn, input logic [31:0] data);
    fwd_valid = 1'b1;
    fwd_rn    = rn;
    fwd_data  = data;
  endtask

  task automatic randomize_inputs();
    id_valid  = 1'($urandom);
    id_rs     = 5'($urandom);
    id_rt     = 5'($urandom);
    id_use_rs = 1'($urandom);
    id_use_rt = 1'($urandom);
    id_wreg   = 1'($urandom);
    id_rd     = 5'($urandom);
    id_lat    = 4'($urandom_range(1, 8));
    flush     = 1'($urandom);
    rf_q1     = $urandom;
    rf_q2     = $urandom;
    fwd_valid = 1'($urandom);
    fwd_rn    = 5'($urandom);
    fwd_data  = $urandom;
  endtask

  // The bench schedules the forward bus by hand; the DUT's slot and counter
  // state must agree with that schedule every cycle outside reset.
  always @(negedge clock) begin
    if (!reset) begin
      chk("slot0_vs_fwd", 64'(dut.slot_q[0]), 64'(fwd_valid));
      if (fwd_valid) begin
        chk("cnt_at_fwd", 64'(dut.cnt_rd[fwd_rn]), 64'd1);
      end
    end
  end

  initial begin
    reset = 1'b1;
    idle();

    // reset held two cycles with random inputs
    randomize_inputs();
    nxt();
    for (int i = 0; i < 2; i++) begin
      randomize_inputs();
      #1;
      chk("rst_pending", 64'(pending), 64'd0);
      chk("rst_stall", 64'(stall), 64'd0);
      chk("rst_issue", 64'(issue), 64'(id_valid & ~flush));
      nxt();
    end
    reset = 1'b0;

    // RAW, L=3 on r5
    idle(); wr(5'd5, 4'd3); #1;
    chk("raw_c0_issue", 64'(issue), 64'd1);
    chk("raw_c0_stall", 64'(stall), 64'd0);
    for (int c = 1; c <= 2; c++) begin
      nxt(); idle();
      id_valid = 1'b1; id_use_rs = 1'b1; id_rs = 5'd5; id_use_rt = 1'b1; id_rt = 5'd6;
      rf_q1 = 32'h1111_1111; rf_q2 = 32'h0000_CAFE; #1;
      chk("raw_stall", 64'(stall), 64'd1);
      chk("raw_no_issue", 64'(issue), 64'd0);
      chk("raw_pending5", 64'(pending[5]), 64'd1);
    end
    nxt(); idle();
    id_valid = 1'b1; id_use_rs = 1'b1; id_rs = 5'd5; id_use_rt = 1'b1; id_rt = 5'd6;
    rf_q1 = 32'h1111_1111; rf_q2 = 32'h0000_CAFE;
    fwd(5'd5, 32'hDEAD_BEEF); #1;
    chk("raw_c3_stall", 64'(stall), 64'd0);
    chk("raw_c3_issue", 64'(issue), 64'd1);
    chk("raw_c3_da", 64'(da), 64'hDEAD_BEEF);
    chk("raw_c3_db", 64'(db), 64'h0000_CAFE);
    nxt(); idle(); #1;
    chk("raw_c4_pending", 64'(pending), 64'd0);

    // WAW on r7: L=4 then L=1
    nxt(); idle(); wr(5'd7, 4'd4); #1;
    chk("waw_c0_issue", 64'(issue), 64'd1);
    for (int c = 1; c <= 3; c++) begin
      nxt(); idle(); wr(5'd7, 4'd1); #1;
      chk("waw_stall", 64'(stall), 64'd1);
      chk("waw_no_issue", 64'(issue), 64'd0);
    end
    nxt(); idle(); wr(5'd7, 4'd1); fwd(5'd7, 32'hA1A1_A1A1); #1;
    chk("waw_c4_stall", 64'(stall), 64'd0);
    chk("waw_c4_issue", 64'(issue), 64'd1);
    nxt(); idle(); fwd(5'd7, 32'hA2A2_A2A2); #1;
    chk("waw_c5_cnt7", 64'(dut.cnt_rd[7]), 64'd1);
    nxt(); idle(); #1;
    chk("waw_c6_pending", 64'(pending), 64'd0);

    // slot conflict: r2 L=3 then r3 L=2
    nxt(); idle(); wr(5'd2, 4'd3); #1;
    chk("slot_c0_issue", 64'(issue), 64'd1);
    nxt(); idle(); wr(5'd3, 4'd2); #1;
    chk("slot_c1_stall", 64'(stall), 64'd1);
    chk("slot_c1_no_issue", 64'(issue), 64'd0);
    nxt(); idle(); wr(5'd3, 4'd2); #1;
    chk("slot_c2_stall", 64'(stall), 64'd0);
    chk("slot_c2_issue", 64'(issue), 64'd1);
    nxt(); idle(); fwd(5'd2, 32'h0000_0002); #1;
    chk("slot_c3_cnt3", 64'(dut.cnt_rd[3]), 64'd2);
    nxt(); idle(); fwd(5'd3, 32'h0000_0003); #1;
    chk("slot_c4_cnt3", 64'(dut.cnt_rd[3]), 64'd1);
    nxt(); idle(); #1;
    chk("slot_c5_pending", 64'(pending), 64'd0);

    // writes to r0 reserve nothing, reads of r0 give zero
    nxt(); idle(); wr(5'd0, 4'd5); #1;
    chk("r0_c0_issue", 64'(issue), 64'd1);
    nxt(); idle();
    id_valid = 1'b1; id_use_rs = 1'b1; id_rs = 5'd0; rf_q1 = 32'h0000_1234; #1;
    chk("r0_stall", 64'(stall), 64'd0);
    chk("r0_da", 64'(da), 64'd0);
    chk("r0_pending", 64'(pending), 64'd0);
    chk("r0_slot", 64'(dut.slot_q), 64'd0);

    // flush together with a stall, then flush with no hazard
    nxt(); idle(); wr(5'd12, 4'd3); #1;
    chk("fl_c0_issue", 64'(issue), 64'd1);
    nxt(); idle(); wr(5'd10, 4'd2);
    id_use_rs = 1'b1; id_rs = 5'd12; flush = 1'b1; #1;
    chk("fl_c1_stall", 64'(stall), 64'd1);
    chk("fl_c1_issue", 64'(issue), 64'd0);
    chk("fl_c1_cnt12", 64'(dut.cnt_rd[12]), 64'd3);
    nxt(); idle(); wr(5'd11, 4'd4); flush = 1'b1; #1;
    chk("fl_c2_stall", 64'(stall), 64'd0);
    chk("fl_c2_issue", 64'(issue), 64'd0);
    chk("fl_c2_cnt10", 64'(dut.cnt_rd[10]), 64'd0);
    chk("fl_c2_cnt12", 64'(dut.cnt_rd[12]), 64'd2);
    nxt(); idle(); fwd(5'd12, 32'h0000_000C); #1;
    chk("fl_c3_cnt11", 64'(dut.cnt_rd[11]), 64'd0);
    chk("fl_c3_pending", 64'(pending), 64'h0000_1000);
    nxt(); idle(); #1;
    chk("fl_c4_pending", 64'(pending), 64'd0);

    // reset while r9 is in flight
    nxt(); idle(); wr(5'd9, 4'd3); #1;
    chk("rs_c0_issue", 64'(issue), 64'd1);
    nxt(); idle(); reset = 1'b1; #1;
    chk("rs_c1_cnt9", 64'(dut.cnt_rd[9]), 64'd3);
    chk("rs_c1_pending9", 64'(pending[9]), 64'd1);
    nxt(); idle(); reset = 1'b0;
    id_valid = 1'b1; id_use_rs = 1'b1; id_rs = 5'd9; rf_q1 = 32'h0000_0055; #1;
    chk("rs_c2_pending", 64'(pending), 64'd0);
    chk("rs_c2_stall", 64'(stall), 64'd0);
    chk("rs_c2_da", 64'(da), 64'h0000_0055);
    nxt(); idle(); #1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_pl_id_scoreboard
`default_nettype wire

// File: doc/pl_id_scoreboard.md
# pl_id_scoreboard

Parametrised hazard and forwarding unit for the decode stage of the pipelined CPU. It generalises the fixed EX/MEM forwarding and load-use interlock to producers of any latency from 1 to MAXLAT, such as loads and multi-cycle mul/div. It keeps a per-register countdown scoreboard and a writeback-slot reservation shift register, and from them produces the stall and issue signals. It also supplies the forwarded operands da and db. The block sits between the register file read ports and the ID/EX pipeline register.

## Interface
Parameters:
- NREG, default 32: number of architectural registers; r0 is hard-wired to zero.
- AW, default $clog2(NREG): register index width.
- DW, default 32: data width.
- MAXLAT, default 8: maximum producer latency in cycles, minimum 2.
- CW, default $clog2(MAXLAT+1): latency and counter width.

Ports:
- clock, in, 1: the single clock.
- reset, in, 1: synchronous, active-high.
- id_valid, in, 1: a valid instruction is in ID.
- id_rs, id_rt, in, AW: source register indices.
- id_use_rs, id_use_rt, in, 1: the source is actually read.
- id_wreg, in, 1: the instruction writes a register.
- id_rd, in, AW: destination register index.
- id_lat, in, CW: cycles from issue until the result is on the forward bus; range 1..MAXLAT.
- flush, in, 1: squash the instruction in ID (taken branch or jump).
- rf_q1, rf_q2, in, DW: register file read data for rs and rt.
- fwd_valid, in, 1: the forward/writeback bus carries a result this cycle.
- fwd_rn, in, AW: register index on the forward bus.
- fwd_data, in, DW: data on the forward bus.
- stall, out, 1: hold PC and IF/ID; equivalent to ~wpcir.
- issue, out, 1: the ID instruction advances this cycle.
- da, db, out, DW: forwarded operands.
- pending, out, NREG: bit r is set when cnt[r] != 0.

## Operation
- State:
  - cnt[r], CW bits, for r = 1..NREG-1. cnt[0] is constant 0.
  - slot[MAXLAT-1:0]: slot[k] set means a result is due on the forward bus k cycles from now.
- RAW hazard: stall when the source is used, the source is not r0, and cnt[src] > 1.
  - cnt[src] == 1 means the result is on the forward bus this cycle; it is taken through the forward mux.
- WAW hazard: stall when id_wreg and id_rd != 0 and cnt[id_rd] > id_lat. This guarantees in-order completion per register.
- Slot conflict: stall when id_wreg and id_lat < MAXLAT and slot[id_lat] is set. There is a single writeback port.
- Stall is computed only when id_valid is high; stall is 0 otherwise.
- issue = id_valid & ~stall & ~flush.
- When flush and stall are both high, issue = 0 and no scoreboard update happens. Stall still reflects the hazard logic.
- Counter update each cycle:
  - Every nonzero cnt decrements by 1.
  - On issue with id_wreg and id_rd != 0, cnt[id_rd] is loaded with id_lat. The load overrides the decrement.
- Slot update: slot' = (slot >> 1), OR in bit (id_lat-1) on issue with id_wreg and id_rd != 0. Writes to r0 reserve nothing.
- Forward mux for each operand:
  - src == 0 gives 0.
  - Otherwise, fwd_valid && fwd_rn == src gives fwd_data.
  - Otherwise the output is rf_q.
- Flush does not clear in-flight entries; those belong to older, committed instructions.
- Protocol assertions (bench only):
  - fwd_valid == slot[0].
  - cnt[fwd_rn] == 1 whenever fwd_valid.
  - id_lat is within 1..MAXLAT.

## Timing
- Issue at cycle t with latency L: the result is on the forward bus at cycle t+L. The consumer in ID at t+L proceeds and stalls during t+1..t+L-1.
- stall, issue, da, db: combinational from inputs and state in the same cycle, with zero latency.
- cnt, slot, pending: registered, one-cycle update.
- Reset: all cnt = 0, slot = 0. pending = 0 and stall = 0 in the cycle after reset is sampled.
- Reset mid-operation discards every in-flight entry. The surrounding pipeline flushes in the same cycle.

## Structure
- Shared package pl_pkg holds:
  - the default NREG, DW, MAXLAT;
  - a fwd_sel_t enum (ZERO, RF, FWD) used by the operand muxes.
- One sub-module, pl_sb_fwdmux: a per-operand zero/forward/regfile mux, instantiated twice.
- The counter array and slot register stay in the top module.

## Test plan
- Reset: hold reset 2 cycles with random inputs -> pending == 0, stall == 0, issue == id_valid & ~flush.
- RAW, L=3:
  - Stimulus: issue r5 at cycle 0; consumer with rs=5 in ID from cycle 1; fwd_valid, fwd_rn=5, fwd_data=0xDEADBEEF at cycle 3.
  - Required: stall=1 in cycles 1-2; at cycle 3 stall=0 and da=0xDEADBEEF.
- WAW:
  - Stimulus: r7 with L=4 issued at cycle 0, then r7 with L=1 held in ID.
  - Required: stall in cycles 1-3; issue at cycle 4; fwd results for r7 at cycles 4 and 5 in that order.
- Slot conflict:
  - Stimulus: r2 with L=3 at cycle 0, then r3 with L=2 at cycle 1.
  - Required: stall at cycle 1; issue at cycle 2 with the r3 result due at cycle 4.
- r0:
  - Stimulus: issue r0 with L=5, then read rs=0 with rf_q1=0x1234.
  - Required: no stall, da=0, pending[0]=0.
- Flush and reset:
  - Stimulus: flush together with a stall.
  - Required: issue=0 and cnt unchanged.
  - Stimulus: reset with r9 pending at cnt=3.
  - Required: pending=0 the next cycle.
